// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register and return-address handling.
// Define FETCH_RAS_EN for the RAS_DEPTH-entry circular return stack; otherwise a single return register is used.
module fetch_unit #(
    parameter int          PC_W      = 16,
    parameter int          RAS_DEPTH = 8,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            kill,
    input  logic [1:0]      pc_src,
    input  logic            is_call,
    input  logic [PC_W-1:0] jump_target,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [15:0]     id_instr,
    output logic [PC_W-1:0] id_pc,
    output logic            id_valid,
    output logic            ras_underflow,
    output logic            ras_overflow
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] ret_addr;
    logic [PC_W-1:0] ret_top;
    logic            push;
    logic            pop;

    // A CALL sits in decode, so the return point is the word after id_pc.
    assign ret_addr  = id_pc + PC_W'(1);
    assign push      = !stall && (pc_src == 2'd1) && is_call;
    assign pop       = !stall && (pc_src == 2'd3);
    assign imem_addr = pc;

`ifdef FETCH_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0]  ras [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W:0]   count;
    logic             empty;

    assign empty   = (count == '0);
    assign ret_top = empty ? '0 : ras[ptr - PTR_W'(1)];

    // NOTE: the stack array has no reset; count = 0 makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push)
            ras[ptr] <= ret_addr;
    end

    // The pointer wraps, so a push at full depth lands on the oldest entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr           <= '0;
            count         <= '0;
            ras_underflow <= 1'b0;
            ras_overflow  <= 1'b0;
        end else if (!stall) begin
            ras_underflow <= pop && empty;
            if (push) begin
                ptr <= ptr + PTR_W'(1);
                if (count != (PTR_W+1)'(RAS_DEPTH))
                    count <= count + (PTR_W+1)'(1);
                else
                    ras_overflow <= 1'b1;
            end else if (pop && !empty) begin
                ptr   <= ptr - PTR_W'(1);
                count <= count - (PTR_W+1)'(1);
            end
        end
    end
`else
    logic [PC_W-1:0] ret_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ret_reg <= '0;
        else if (push)
            ret_reg <= ret_addr;
    end

    assign ret_top       = ret_reg;
    assign ras_underflow = 1'b0;
    assign ras_overflow  = 1'b0;
`endif

    // NOTE: every path assigns pc_next, so no latch is inferred.
    always_comb begin
        pc_next = pc + PC_W'(1);
        unique case (pc_src)
            2'd0: pc_next = pc + PC_W'(1);
            2'd1: pc_next = jump_target;
            2'd2: pc_next = branch_target;
            2'd3: pc_next = ret_top;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= '0;
            id_instr <= NOP_INSTR;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else if (!stall) begin
            pc    <= pc_next;
            id_pc <= pc;
            if (kill) begin
                id_instr <= NOP_INSTR;
                id_valid <= 1'b0;
            end else begin
                id_instr <= imem_data;
                id_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stimulus against a queue-based model.
// Builds for both settings of FETCH_RAS_EN.
module tb_fetch_unit;

    localparam int          DEPTH = 8;
    localparam logic [15:0] NOP   = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        kill;
    logic [1:0]  pc_src;
    logic        is_call;
    logic [15:0] jump_target;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_valid;
    logic        ras_underflow;
    logic        ras_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    logic [15:0] m_pc, m_instr, m_id_pc, m_ret;
    logic        m_valid, m_uf, m_of;
    logic [15:0] m_q[$];

    fetch_unit #(.PC_W(16), .RAS_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .kill(kill), .pc_src(pc_src),
        .is_call(is_call), .jump_target(jump_target), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .id_instr(id_instr), .id_pc(id_pc),
        .id_valid(id_valid), .ras_underflow(ras_underflow), .ras_overflow(ras_overflow)
    );

    always #5 clk = ~clk;
    assign imem_data = 16'h1000 + imem_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("id_instr", 32'(id_instr), 32'(m_instr));
        check("id_pc", 32'(id_pc), 32'(m_id_pc));
        check("id_valid", 32'(id_valid), 32'(m_valid));
        check("ras_underflow", 32'(ras_underflow), 32'(m_uf));
        check("ras_overflow", 32'(ras_overflow), 32'(m_of));
    endtask

    task automatic model_reset();
        m_pc = 16'h0; m_instr = NOP; m_id_pc = 16'h0; m_valid = 1'b0;
        m_uf = 1'b0; m_of = 1'b0; m_ret = 16'h0;
        m_q.delete();
    endtask

    // One rising edge of the specified behaviour, using the currently driven inputs.
    task automatic model_step();
        logic [15:0] nxt;
        logic        do_push, do_pop;
        if (stall) return;
        do_push = (pc_src == 2'd1) && is_call;
        do_pop  = (pc_src == 2'd3);
        case (pc_src)
            2'd0: nxt = m_pc + 16'd1;
            2'd1: nxt = jump_target;
            2'd2: nxt = branch_target;
            default: begin
`ifdef FETCH_RAS_EN
                if (m_q.size() == 0) nxt = 16'h0;
                else nxt = m_q[m_q.size()-1];
`else
                nxt = m_ret;
`endif
            end
        endcase
`ifdef FETCH_RAS_EN
        m_uf = do_pop && (m_q.size() == 0);
        if (do_push) begin
            m_q.push_back(m_id_pc + 16'd1);
            if (m_q.size() > DEPTH) begin
                void'(m_q.pop_front());
                m_of = 1'b1;
            end
        end else if (do_pop && m_q.size() != 0) begin
            void'(m_q.pop_back());
        end
`else
        if (do_push) m_ret = m_id_pc + 16'd1;
`endif
        m_instr = kill ? NOP : 16'h1000 + m_pc;
        m_valid = !kill;
        m_id_pc = m_pc;
        m_pc    = nxt;
    endtask

    task automatic cycle(input logic st, input logic kl, input logic [1:0] src, input logic cl,
                         input logic [15:0] jt, input logic [15:0] bt);
        stall = st; kill = kl; pc_src = src; is_call = cl;
        jump_target = jt; branch_target = bt;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Redirect to addr, then fetch it normally so that id_pc == addr afterwards.
    task automatic goto_pc(input logic [15:0] addr);
        cycle(1'b0, 1'b1, 2'd1, 1'b0, addr, 16'h0);
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic call_to(input logic [15:0] tgt);
        cycle(1'b0, 1'b1, 2'd1, 1'b1, tgt, 16'h0);
    endtask

    task automatic ret_once();
        cycle(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 16'h0);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic mid_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_ret;
        reset = 1'b1; stall = 1'b0; kill = 1'b0; pc_src = 2'd0; is_call = 1'b0;
        jump_target = 16'h0; branch_target = 16'h0;
        model_reset();
        #3;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Sequential fetch from 0
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0);
        check("seq_pc5", 32'(imem_addr), 32'h5);

        // Jump with kill at PC = 5
        cycle(1'b0, 1'b1, 2'd1, 1'b0, 16'h0040, 16'h0);
        check("jump_bubble", 32'(id_valid), 32'h0);
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0);
        check("jump_instr", 32'(id_instr), 32'h1040);

        // Stall holds at PC = 8 with branch and kill pending
        goto_pc(16'h0007);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 2'd2, 1'b0, 16'h0, 16'h0300);
        check("stall_pc", 32'(imem_addr), 32'h8);
        cycle(1'b0, 1'b1, 2'd2, 1'b0, 16'h0, 16'h0300);
        check("branch_after_stall", 32'(imem_addr), 32'h0300);

        // Nested calls then returns
        goto_pc(16'h0010); call_to(16'h0100);
        goto_pc(16'h0020); call_to(16'h0200);
        ret_once();
        check("ret1", 32'(imem_addr), 32'h0021);
        ret_once();
`ifdef FETCH_RAS_EN
        exp_ret = 16'h0011;
`else
        exp_ret = 16'h0021;
`endif
        check("ret2", 32'(imem_addr), 32'(exp_ret));

        // Return on an empty stack
        ret_once();
`ifdef FETCH_RAS_EN
        check("uf_pc", 32'(imem_addr), 32'h0);
        check("uf_pulse", 32'(ras_underflow), 32'h1);
`else
        check("uf_pc", 32'(imem_addr), 32'h0021);
        check("uf_flag", 32'(ras_underflow), 32'h0);
`endif
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0);
        check("uf_clear", 32'(ras_underflow), 32'h0);

        // Nine calls against an 8-deep stack, then nine returns
        for (int i = 0; i < 9; i++) begin
            goto_pc(16'h0030 + 16'(i * 4));
            call_to(16'h0500 + 16'(i));
        end
`ifdef FETCH_RAS_EN
        check("overflow_set", 32'(ras_overflow), 32'h1);
`else
        check("overflow_tied", 32'(ras_overflow), 32'h0);
`endif
        for (int i = 0; i < 9; i++) ret_once();

        // Randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) mid_reset();
            cycle(($urandom % 5) == 0, ($urandom % 3) == 0, 2'($urandom_range(0, 3)),
                  1'($urandom % 2), 16'($urandom), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
